// File: rtl/mul_div_pkg.sv
// rtl/mul_div_pkg.sv - shared encodings, FSM state type and width default for mul_div_unit
package mul_div_pkg;

  localparam int WIDTH_DEFAULT = 64;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_UMULH = 2'b01,
    OP_SDIV  = 2'b10,
    OP_UDIV  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CALC   = 2'b01,
    FINISH = 2'b10
  } state_e;

endpackage

// File: rtl/mul_div_unit_cond_negate.sv
// rtl/mul_div_unit_cond_negate.sv - conditional two's-complement negation
module cond_negate
  import mul_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] value_fixed
);

  // The most negative value maps onto itself, which is the wrap behaviour SDIV relies on.
  assign value_fixed = negate ? ((~value) + WIDTH'(1)) : value;

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative fixed-latency multiply / divide unit
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [4:0]       dest_in,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       dest_out
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e             state;
  state_e             state_next;
  op_e                op_reg;
  logic [CW-1:0]      count;
  // Multiply: {partial product high, multiplier shifting out low}.
  // Divide:   {partial remainder, dividend shifting into quotient bits}.
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  // Multiplicand for MUL/UMULH, divisor magnitude for SDIV/UDIV.
  logic [WIDTH-1:0]   opnd;
  logic [4:0]         dest_reg;
  logic               neg_q;
  logic               div_zero;

  logic               is_sdiv_in;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   q_fixed;
  logic [WIDTH-1:0]   final_result;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_sub;
  logic               rem_ge;

  assign is_sdiv_in = (OP == OP_SDIV);

  cond_negate #(.WIDTH(WIDTH)) u_neg_a (
    .value       (a_in),
    .negate      (is_sdiv_in & a_in[WIDTH-1]),
    .value_fixed (a_mag)
  );

  cond_negate #(.WIDTH(WIDTH)) u_neg_b (
    .value       (b_in),
    .negate      (is_sdiv_in & b_in[WIDTH-1]),
    .value_fixed (b_mag)
  );

  cond_negate #(.WIDTH(WIDTH)) u_neg_q (
    .value       (acc[WIDTH-1:0]),
    .negate      (neg_q),
    .value_fixed (q_fixed)
  );

  // One iteration step: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    rem_ge   = (rem_sh >= {1'b0, opnd});
    // When the trial subtract succeeds the difference is below 2^WIDTH, so the low bits suffice.
    rem_sub  = rem_sh[WIDTH-1:0] - opnd;
    if (op_reg == OP_MUL || op_reg == OP_UMULH) begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end else begin
      acc_step = {(rem_ge ? rem_sub : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], rem_ge};
    end
  end

  // Select the architectural result; a zero divisor overrides the all-ones raw quotient.
  always_comb begin
    final_result = '0;
    case (op_reg)
      OP_MUL:   final_result = acc[WIDTH-1:0];
      OP_UMULH: final_result = acc[2*WIDTH-1:WIDTH];
      OP_SDIV:  final_result = div_zero ? '0 : q_fixed;
      default:  final_result = div_zero ? '0 : acc[WIDTH-1:0];
    endcase
  end

  // FSM state register; reset wins over any START.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and BUSY decode; BUSY covers CALC and FINISH so it is low in the DONE cycle.
  always_comb begin
    state_next = state;
    BUSY       = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          state_next = CALC;
        end
      end
      CALC: begin
        BUSY = 1'b1;
        if (count == LAST) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        BUSY       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture, iteration, and result/DONE registration.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      op_reg   <= OP_MUL;
      dest_reg <= '0;
      neg_q    <= 1'b0;
      div_zero <= 1'b0;
      result   <= '0;
      dest_out <= '0;
      DONE     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            op_reg   <= op_e'(OP);
            dest_reg <= dest_in;
            count    <= '0;
            neg_q    <= is_sdiv_in & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
            div_zero <= (b_in == '0);
            if (OP == OP_MUL || OP == OP_UMULH) begin
              opnd <= a_in;
              acc  <= {{WIDTH{1'b0}}, b_in};
            end else begin
              opnd <= b_mag;
              acc  <= {{WIDTH{1'b0}}, a_mag};
            end
          end
        end
        CALC: begin
          acc   <= acc_step;
          count <= count + CW'(1);
        end
        FINISH: begin
          result   <= final_result;
          dest_out <= dest_reg;
          DONE     <= 1'b1;
        end
        default: begin
          DONE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit
module tb_mul_div_unit;
  import mul_div_pkg::*;

  localparam int W   = 64;
  localparam int LAT = W + 1;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         START;
  logic [1:0]   OP;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [4:0]   dest_in;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] result;
  logic [4:0]   dest_out;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   dest;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[14];

  mul_div_unit #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .START    (START),
    .OP       (OP),
    .a_in     (a_in),
    .b_in     (b_in),
    .dest_in  (dest_in),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .result   (result),
    .dest_out (dest_out)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Launch one operation and follow it to DONE; lat counts negedges after the START edge.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] dest, input bit no_wait,
                        output int lat, output int busy_err,
                        output logic [W-1:0] mid_result, output logic [4:0] mid_dest);
    if (!no_wait) @(negedge CLK);
    START   = 1'b1;
    OP      = op;
    a_in    = a;
    b_in    = b;
    dest_in = dest;
    @(negedge CLK);
    START   = 1'b0;
    OP      = ~op;
    a_in    = ~a;
    b_in    = ~b;
    dest_in = ~dest;
    lat        = -1;
    busy_err   = 0;
    mid_result = '0;
    mid_dest   = '0;
    for (int k = 0; k <= LAT + 20; k++) begin
      if (k == 10) begin
        mid_result = result;
        mid_dest   = dest_out;
      end
      if (DONE) begin
        lat = k;
        if (BUSY) busy_err++;
        break;
      end
      if (!BUSY) busy_err++;
      @(negedge CLK);
    end
  endtask

  initial begin
    int           lat;
    int           busy_err;
    int           done_cnt;
    logic [W-1:0] mid_r;
    logic [4:0]   mid_d;
    logic [W-1:0] got;

    vecs[0]  = '{OP_MUL,   64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd1, 64'hFFFF_FFFF_FFFF_FFEB};
    vecs[1]  = '{OP_UMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[2]  = '{OP_MUL,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 64'd1};
    vecs[3]  = '{OP_SDIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFD};
    vecs[4]  = '{OP_UDIV,  64'd100, 64'd7, 5'd5, 64'd14};
    vecs[5]  = '{OP_SDIV,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, 64'h8000_0000_0000_0000};
    vecs[6]  = '{OP_UDIV,  64'd99999, 64'd0, 5'd7, 64'd0};
    vecs[7]  = '{OP_SDIV,  64'd99999, 64'd0, 5'd8, 64'd0};
    vecs[8]  = '{OP_SDIV,  64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd9, 64'hFFFF_FFFF_FFFF_FFFD};
    vecs[9]  = '{OP_UMULH, 64'h1_0000_0000, 64'h1_0000_0000, 5'd10, 64'd1};
    vecs[10] = '{OP_SDIV,  64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 5'd11, 64'd14};
    vecs[11] = '{OP_UDIV,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd12, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[12] = '{OP_MUL,   64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFB, 5'd13, 64'd25};
    vecs[13] = '{OP_UMULH, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd31, 64'd6};

    RESET = 1'b1; START = 1'b0; OP = 2'b00; a_in = '0; b_in = '0; dest_in = '0;
    repeat (3) @(negedge CLK);
    check("reset_busy", W'(BUSY), '0);
    check("reset_done", W'(DONE), '0);
    check("reset_result", result, '0);
    check("reset_dest", W'(dest_out), '0);

    START = 1'b1;
    @(negedge CLK);
    check("reset_over_start_busy", W'(BUSY), '0);
    START = 1'b0;
    RESET = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest, 1'b0, lat, busy_err, mid_r, mid_d);
      check($sformatf("vec%0d_latency", i), W'(lat), W'(LAT));
      check($sformatf("vec%0d_result", i), result, vecs[i].exp);
      check($sformatf("vec%0d_dest", i), W'(dest_out), W'(vecs[i].dest));
      check($sformatf("vec%0d_busy", i), W'(busy_err), '0);
    end

    // START held high through CALC: only the first request counts.
    @(negedge CLK);
    START = 1'b1; OP = OP_MUL; a_in = 64'd3; b_in = 64'd4; dest_in = 5'd3;
    @(negedge CLK);
    a_in = 64'd100; b_in = 64'd100; dest_in = 5'd30; OP = OP_UDIV;
    repeat (30) @(negedge CLK);
    START = 1'b0;
    done_cnt = 0;
    got = '0;
    for (int k = 0; k < 120; k++) begin
      @(negedge CLK);
      if (DONE) begin
        done_cnt++;
        got = result;
      end
    end
    check("held_start_done_count", W'(done_cnt), W'(1));
    check("held_start_result", got, 64'd12);
    check("held_start_dest", W'(dest_out), W'(3));

    // Back-to-back: second START presented in the DONE cycle.
    run_op(OP_UDIV, 64'd100, 64'd7, 5'd5, 1'b0, lat, busy_err, mid_r, mid_d);
    check("b2b_first_result", result, 64'd14);
    run_op(OP_MUL, 64'd6, 64'd7, 5'd9, 1'b1, lat, busy_err, mid_r, mid_d);
    check("b2b_hold_result", mid_r, 64'd14);
    check("b2b_hold_dest", W'(mid_d), W'(5));
    check("b2b_latency", W'(lat), W'(LAT));
    check("b2b_result", result, 64'd42);
    check("b2b_dest", W'(dest_out), W'(9));

    // Reset in the middle of a divide aborts it with no DONE.
    @(negedge CLK);
    START = 1'b1; OP = OP_UDIV; a_in = 64'd1000; b_in = 64'd3; dest_in = 5'd7;
    @(negedge CLK);
    START = 1'b0;
    repeat (29) @(negedge CLK);
    RESET = 1'b1;
    START = 1'b1;
    @(negedge CLK);
    check("abort_busy", W'(BUSY), '0);
    check("abort_done", W'(DONE), '0);
    check("abort_result", result, '0);
    check("abort_dest", W'(dest_out), '0);
    RESET = 1'b0;
    START = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (DONE) done_cnt++;
    end
    check("abort_no_done", W'(done_cnt), '0);
    run_op(OP_MUL, 64'd6, 64'd7, 5'd2, 1'b0, lat, busy_err, mid_r, mid_d);
    check("post_reset_latency", W'(lat), W'(LAT));
    check("post_reset_result", result, 64'd42);
    check("post_reset_dest", W'(dest_out), W'(2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter WIDTH, default 64, operand/result width in bits.
REQ-002 CLK  input  1  sole clock, all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 START  input  1  request strobe; sampled only in IDLE.
REQ-005 OP  input  2  operation: 00 MUL (low product), 01 UMULH (high unsigned product), 10 SDIV, 11 UDIV.
REQ-006 a_in  input  WIDTH  operand A (Rn, from register file read_data1).
REQ-007 b_in  input  WIDTH  operand B (Rm, from register file read_data2).
REQ-008 dest_in  input  5  destination register index, captured with the operands.
REQ-009 BUSY  output  1  high while an operation is in flight.
REQ-010 DONE  output  1  one-cycle pulse marking a valid result.
REQ-011 result  output  WIDTH  registered result, held until the next accepted START.
REQ-012 dest_out  output  5  captured dest_in, driven alongside result for the register-file write port.

Function
REQ-013 The block SHALL implement FSM states IDLE, CALC and FINISH.
REQ-014 In IDLE with START=1 at edge E0, the block SHALL capture OP, dest_in, and operands, load a bit counter with 0, and enter CALC.
REQ-015 In IDLE, OP and operands SHALL be ignored when START=0; START outside IDLE SHALL be ignored with no state change.
REQ-016 CALC SHALL process one operand bit per cycle, WIDTH cycles in total: shift-add for MUL/UMULH, restoring shift-subtract for SDIV/UDIV.
REQ-017 When the counter reaches WIDTH-1, the FSM SHALL move to FINISH; FINISH SHALL last one cycle, register result, pulse DONE and return to IDLE.
REQ-018 Latency SHALL be fixed: DONE=1 in the cycle after edge E0+WIDTH+1 for every OP and operand value, including divide-by-zero.
REQ-019 BUSY SHALL be 1 from the cycle after E0 through the cycle after E0+WIDTH, and 0 when DONE=1.
REQ-020 A START sampled in the DONE cycle SHALL be accepted, allowing back-to-back operations.
REQ-021 MUL SHALL return product bits [WIDTH-1:0], identical for signed and unsigned operands.
REQ-022 UMULH SHALL return bits [2*WIDTH-1:WIDTH] of the unsigned 2*WIDTH product.
REQ-023 UDIV SHALL return the unsigned quotient floor(a/b).
REQ-024 SDIV SHALL divide magnitudes, truncate toward zero, and negate the quotient when the operand signs differ.
REQ-025 Division with b_in=0 SHALL return 0 for SDIV and UDIV.
REQ-026 SDIV of the most negative value by -1 SHALL return the most negative value (wrap, no trap).
REQ-027 result and dest_out SHALL change only in FINISH or on reset.

Reset
REQ-028 RESET=1 at any edge SHALL force IDLE, BUSY=0, DONE=0, result=0, dest_out=0, and counter=0.
REQ-029 RESET mid-operation SHALL abort the operation without any DONE pulse; the first START after RESET deasserts SHALL be accepted normally.
REQ-030 RESET SHALL take priority over START in the same cycle.

Structure
REQ-031 Package mul_div_pkg SHALL hold the OP encodings (OP_MUL, OP_UMULH, OP_SDIV, OP_UDIV), the FSM state type, and the WIDTH default.
REQ-032 One sub-module, cond_negate, SHALL perform WIDTH-bit conditional two's-complement negation and serve both SDIV operand magnitude and quotient sign fix.
REQ-033 The FSM, counter, and 2*WIDTH accumulator SHALL reside in mul_div_unit.

Verification
REQ-034 MUL a=7, b=-3 (0xFFFF_FFFF_FFFF_FFFD) -> result 0xFFFF_FFFF_FFFF_FFEB (-21), DONE exactly 66 cycles after the START edge.
REQ-035 UMULH a=b=0xFFFF_FFFF_FFFF_FFFF -> result 0xFFFF_FFFF_FFFF_FFFE; MUL with the same operands -> 1.
REQ-036 SDIV a=-7, b=2 -> -3; UDIV a=100, b=7 -> 14; SDIV a=0x8000_0000_0000_0000, b=-1 -> 0x8000_0000_0000_0000.
REQ-037 UDIV and SDIV a=99999, b=0 -> result 0, with DONE at the normal 66-cycle latency.
REQ-038 START held high through CALC -> a single operation and a single DONE; a second START in the DONE cycle -> accepted, second DONE 66 cycles later with dest_out updated.
REQ-039 RESET asserted at cycle 30 of a UDIV -> no DONE pulse, BUSY=0, result=0; the next MUL 6*7 -> 42.
